// File: rtl/stack_ctrl_if.sv
// Bundle between the stack controller, its datapath client and the single-port stack memory.
// master = controller side, slave = datapath/memory side.
interface stack_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 1024
);
  localparam int AW = $clog2(NWORDS);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] wdata;
  logic             clear;
  logic             ready;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;
  logic             conflict;
  logic [AW-1:0]    mem_a;
  logic             mem_we;
  logic [WIDTH-1:0] mem_din;
  logic [WIDTH-1:0] mem_dout;

  modport master (
    input  push, pop, wdata, clear, mem_dout,
    output ready, rdata, rvalid, empty, full, count,
           overflow, underflow, conflict, mem_a, mem_we, mem_din
  );

  modport slave (
    output push, pop, wdata, clear, mem_dout,
    input  ready, rdata, rvalid, empty, full, count,
           overflow, underflow, conflict, mem_a, mem_we, mem_din
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack controller: owns the stack pointer, serves push/pop with one-cycle memory access
// phases, returns popped words with a strobe and latches overflow/underflow/conflict.
module stack_ctrl #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 1024
) (
  input logic          clk,
  input logic          reset_n,
  stack_ctrl_if.master bus
);
  localparam int AW = $clog2(NWORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PUSH  = 2'd1;
  localparam logic [1:0] S_POP   = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(NWORDS);

  logic [1:0]       r_state;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_conflict;

  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_top   = r_count[AW-1:0] - AW'(1);

  assign bus.ready     = (r_state == S_IDLE);
  assign bus.mem_we    = (r_state == S_PUSH);
  assign bus.mem_a     = (r_state == S_PUSH) ? r_count[AW-1:0] : w_top;
  assign bus.mem_din   = r_wdata;
  assign bus.rdata     = r_rdata;
  assign bus.rvalid    = r_rvalid;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
  assign bus.conflict  = r_conflict;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_conflict  <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A flag raised this cycle wins over a simultaneous clear.
          if (bus.clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_conflict  <= 1'b0;
          end
          if (bus.push && bus.pop) begin
            r_conflict <= 1'b1;
            r_state    <= S_ERROR;
          end else if (bus.push) begin
            if (w_full) begin
              r_overflow <= 1'b1;
              r_state    <= S_ERROR;
            end else begin
              r_wdata <= bus.wdata;
              r_state <= S_PUSH;
            end
          end else if (bus.pop) begin
            if (w_empty) begin
              r_underflow <= 1'b1;
              r_state     <= S_ERROR;
            end else begin
              r_state <= S_POP;
            end
          end
        end
        S_PUSH: begin
          r_count <= r_count + (AW+1)'(1);
          r_state <= S_IDLE;
        end
        S_POP: begin
          r_rdata  <= bus.mem_dout;
          r_rvalid <= 1'b1;
          r_count  <= r_count - (AW+1)'(1);
          r_state  <= S_IDLE;
        end
        S_ERROR: begin
          if (bus.clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_conflict  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl with a 4-deep stack: directed table, corner sequences, then random
// traffic against a queue-based reference model.
module tb_stack_ctrl;
  localparam int WIDTH  = 16;
  localparam int NWORDS = 4;
  localparam int AW     = $clog2(NWORDS);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  stack_ctrl_if #(.WIDTH(WIDTH), .NWORDS(NWORDS)) bus ();

  stack_ctrl #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural stack memory: async read, write on posedge.
  logic [WIDTH-1:0] mem [NWORDS];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a] <= bus.mem_din;
  assign bus.mem_dout = mem[bus.mem_a];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic p, input logic q, input logic c, input logic [WIDTH-1:0] w);
    bus.push  = p;
    bus.pop   = q;
    bus.clear = c;
    bus.wdata = w;
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.overflow, bus.underflow, bus.conflict};
  endfunction

  typedef struct {
    logic             push, pop, clr;
    logic [WIDTH-1:0] wd;
    logic             ready;
    logic [AW:0]      cnt;
    logic             we;
    logic             chk_a;
    logic [AW-1:0]    a;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
    logic [2:0]       flg;
  } vec_t;

  function automatic vec_t mk(input int p, input int q, input int c, input int wd,
                              input int rdy, input int cnt, input int we, input int ca,
                              input int a, input int rv, input int rd, input int fl);
    vec_t v;
    v.push = 1'(p);  v.pop = 1'(q);  v.clr = 1'(c);  v.wd = WIDTH'(wd);
    v.ready = 1'(rdy); v.cnt = (AW+1)'(cnt); v.we = 1'(we); v.chk_a = 1'(ca);
    v.a = AW'(a); v.rvalid = 1'(rv); v.rdata = WIDTH'(rd); v.flg = 3'(fl);
    return v;
  endfunction

  vec_t tbl [17];

  // One push: accept cycle then write cycle; returns at the following negedge.
  task automatic do_push(input logic [WIDTH-1:0] w, input int slot);
    drive(1'b1, 1'b0, 1'b0, w);
    #1 chk("push_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0);
    #1 chk("push_we", 32'(bus.mem_we), 32'd1);
    chk("push_addr", 32'(bus.mem_a), 32'(slot));
    @(negedge clk);
  endtask

  task automatic do_pop(input logic [WIDTH-1:0] exp);
    drive(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1 chk("pop_rvalid", 32'(bus.rvalid), 32'd1);
    chk("pop_rdata", 32'(bus.rdata), 32'(exp));
    @(negedge clk);
  endtask

  // Reference model state
  logic [WIDTH-1:0] q[$];
  bit               m_err, m_busy, m_bpush, m_rv, m_ov, m_un, m_cf;
  logic [WIDTH-1:0] m_pend, m_last;

  initial begin
    tbl[0]  = mk(1,0,0,'h1111, 1,0,0,0,0, 0,'h0000,0);
    tbl[1]  = mk(0,0,0,0,      0,0,1,1,0, 0,'h0000,0);
    tbl[2]  = mk(1,0,0,'h2222, 1,1,0,0,0, 0,'h0000,0);
    tbl[3]  = mk(0,0,0,0,      0,1,1,1,1, 0,'h0000,0);
    tbl[4]  = mk(1,0,0,'h3333, 1,2,0,0,0, 0,'h0000,0);
    tbl[5]  = mk(0,0,0,0,      0,2,1,1,2, 0,'h0000,0);
    tbl[6]  = mk(0,1,0,0,      1,3,0,0,0, 0,'h0000,0);
    tbl[7]  = mk(0,0,0,0,      0,3,0,1,2, 0,'h0000,0);
    tbl[8]  = mk(0,1,0,0,      1,2,0,0,0, 1,'h3333,0);
    tbl[9]  = mk(0,0,0,0,      0,2,0,1,1, 0,'h3333,0);
    tbl[10] = mk(0,1,0,0,      1,1,0,0,0, 1,'h2222,0);
    tbl[11] = mk(0,0,0,0,      0,1,0,1,0, 0,'h2222,0);
    tbl[12] = mk(0,0,0,0,      1,0,0,0,0, 1,'h1111,0);
    tbl[13] = mk(0,1,0,0,      1,0,0,0,0, 0,'h1111,0);
    tbl[14] = mk(0,0,0,0,      0,0,0,0,0, 0,'h1111,2);
    tbl[15] = mk(0,0,1,0,      0,0,0,0,0, 0,'h1111,2);
    tbl[16] = mk(0,0,0,0,      1,0,0,0,0, 0,'h1111,0);

    drive(1'b0, 1'b0, 1'b0, '0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_flags", flags(), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    reset_n = 1'b1;
    #1 chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_empty", 32'(bus.empty), 32'd1);

    // Directed table: push 3, pop 3, underflow and clear
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].wd);
      #1;
      chk($sformatf("t%0d_ready", i), 32'(bus.ready), 32'(tbl[i].ready));
      chk($sformatf("t%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_empty", i), 32'(bus.empty), 32'(tbl[i].cnt == 0));
      chk($sformatf("t%0d_we", i), 32'(bus.mem_we), 32'(tbl[i].we));
      if (tbl[i].chk_a) chk($sformatf("t%0d_addr", i), 32'(bus.mem_a), 32'(tbl[i].a));
      if (tbl[i].we && i > 0) chk($sformatf("t%0d_din", i), 32'(bus.mem_din), 32'(tbl[i-1].wd));
      chk($sformatf("t%0d_rvalid", i), 32'(bus.rvalid), 32'(tbl[i].rvalid));
      chk($sformatf("t%0d_rdata", i), 32'(bus.rdata), 32'(tbl[i].rdata));
      chk($sformatf("t%0d_flags", i), flags(), 32'(tbl[i].flg));
      @(negedge clk);
    end

    // Fill to NWORDS, then overflow
    for (int i = 0; i < NWORDS; i++) do_push(WIDTH'(16'hA000 + i), i);
    chk("fill_count", 32'(bus.count), 32'(NWORDS));
    chk("fill_full", 32'(bus.full), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'hBEEF);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0);
    #1 chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_ready", 32'(bus.ready), 32'd0);
    chk("ovf_we", 32'(bus.mem_we), 32'd0);
    chk("ovf_count", 32'(bus.count), 32'(NWORDS));
    @(negedge clk);
    #1 chk("ovf_we2", 32'(bus.mem_we), 32'd0);
    drive(1'b0, 1'b0, 1'b1, '0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0);
    #1 chk("ovf_clr_flag", 32'(bus.overflow), 32'd0);
    chk("ovf_clr_ready", 32'(bus.ready), 32'd1);
    chk("ovf_clr_count", 32'(bus.count), 32'(NWORDS));
    do_pop(16'hA003);
    do_pop(16'hA002);
    chk("pre_cf_count", 32'(bus.count), 32'd2);

    // Conflict with count=2
    drive(1'b1, 1'b1, 1'b0, 16'h5555);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0);
    #1 chk("cf_flag", 32'(bus.conflict), 32'd1);
    chk("cf_we", 32'(bus.mem_we), 32'd0);
    chk("cf_count", 32'(bus.count), 32'd2);
    chk("cf_rvalid", 32'(bus.rvalid), 32'd0);
    @(negedge clk);
    #1 chk("cf_rvalid2", 32'(bus.rvalid), 32'd0);
    chk("cf_count2", 32'(bus.count), 32'd2);
    drive(1'b0, 1'b0, 1'b1, '0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0);

    // Reset during a PUSH cycle
    drive(1'b1, 1'b0, 1'b0, 16'h7777);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0);
    #1 chk("rp_we_before", 32'(bus.mem_we), 32'd1);
    reset_n = 1'b0;
    #1 chk("rp_we_after", 32'(bus.mem_we), 32'd0);
    chk("rp_count", 32'(bus.count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rp_ready", 32'(bus.ready), 32'd1);
    chk("rp_count2", 32'(bus.count), 32'd0);
    @(negedge clk);

    // Random traffic vs reference model (DUT freshly reset above)
    q.delete();
    m_err = 0; m_busy = 0; m_bpush = 0; m_rv = 0;
    m_ov = 0; m_un = 0; m_cf = 0; m_pend = '0; m_last = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int r;
      logic p, pp, c;
      logic [WIDTH-1:0] w;
      bit nrv;
      r  = int'($urandom_range(0, 99));
      p  = (r < 45) || (r >= 85 && r < 89);
      pp = (r >= 45 && r < 89);
      c  = ($urandom_range(0, 3) == 0);
      w  = WIDTH'($urandom);
      drive(p, pp, c, w);
      #1;
      chk("rnd_ready", 32'(bus.ready), 32'(!m_busy && !m_err));
      chk("rnd_count", 32'(bus.count), 32'(q.size()));
      chk("rnd_empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("rnd_full", 32'(bus.full), 32'(q.size() == NWORDS));
      chk("rnd_rvalid", 32'(bus.rvalid), 32'(m_rv));
      chk("rnd_rdata", 32'(bus.rdata), 32'(m_last));
      chk("rnd_flags", flags(), {29'd0, m_ov, m_un, m_cf});
      chk("rnd_we", 32'(bus.mem_we), 32'(m_busy && m_bpush));
      if (m_busy && m_bpush) begin
        chk("rnd_waddr", 32'(bus.mem_a), 32'(q.size()));
        chk("rnd_din", 32'(bus.mem_din), 32'(m_pend));
      end
      nrv = 0;
      if (m_busy) begin
        if (m_bpush) q.push_back(m_pend);
        else begin
          m_last = q.pop_back();
          nrv = 1;
        end
        m_busy = 0;
      end else if (m_err) begin
        if (c) begin
          m_err = 0; m_ov = 0; m_un = 0; m_cf = 0;
        end
      end else begin
        if (c) begin
          m_ov = 0; m_un = 0; m_cf = 0;
        end
        if (p && pp) begin
          m_cf = 1; m_err = 1;
        end else if (p) begin
          if (q.size() == NWORDS) begin
            m_ov = 1; m_err = 1;
          end else begin
            m_busy = 1; m_bpush = 1; m_pend = w;
          end
        end else if (pp) begin
          if (q.size() == 0) begin
            m_un = 1; m_err = 1;
          end else begin
            m_busy = 1; m_bpush = 0;
          end
        end
      end
      m_rv = nrv;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
